mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between an instruction cache and a
// data cache. The data cache normally wins contention, and a two-word block
// lock keeps an aligned dcache pair together. A starvation counter hands the
// RAM to the icache after STARVE_MAX consecutive dcache wins over a pending
// icache request.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  // icache side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // dcache side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
);

  localparam int CW = $clog2(STARVE_MAX) + 1;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IACC  = 2'd1,
    DACC  = 2'd2,
    DHOLD = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   starve_cnt, starve_next;
  logic            dreq;

  assign dreq = dREN | dWEN;

  // State register and starvation counter; synchronous reset aborts any access.
  always_ff @(posedge CLK) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Next-state, counter update and RAM request decode.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    state_next  = state;
    starve_next = starve_cnt;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state)
      IDLE: begin
        // dcache wins contention unless the icache has been starved too long.
        if (dreq && !(iREN && starve_cnt == STARVE_LIM)) begin
          state_next = DACC;
          if (iREN && starve_cnt != STARVE_LIM)
            starve_next = starve_cnt + CW'(1);
        end else if (iREN) begin
          state_next  = IACC;
          starve_next = '0;
        end
      end

      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN || ramready)
          state_next = IDLE;
      end

      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        // A simultaneous read and write request is served as a write.
        if (dWEN)
          ramWEN = 1'b1;
        else if (dREN)
          ramREN = 1'b1;

        if (!dreq)
          state_next = IDLE;
        else if (ramready)
          state_next = daddr[2] ? IDLE : DHOLD;
      end

      DHOLD: begin
        // RAM idle for one cycle; the block partner keeps priority over icache.
        state_next = dreq ? DACC : IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign iwait = !(state == IACC && ramready);
  assign dwait = !(state == DACC && ramready);
  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs change on the falling clock edge,
// outputs are sampled 1 ns later, state updates on the rising edge.
module tb_mem_arbiter;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IACC  = 2'd1;
  localparam logic [1:0] S_DACC  = 2'd2;
  localparam logic [1:0] S_DHOLD = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic at_neg();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = 32'hCAFE_0001;
    @(posedge CLK); @(posedge CLK);
    at_neg(); RST = 1'b0; #1;
    checks++; if (dut.state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dut.state, S_IDLE); end
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL reset_ram_en got %b%b exp 00", ramREN, ramWEN); end
    checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL reset_ram_bus got %h/%h exp 0/0", ramaddr, ramstore); end
    checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL reset_waits got %b%b exp 11", iwait, dwait); end
    checks++; if (dut.starve_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", dut.starve_cnt); end
    checks++; if (iload !== 32'hCAFE_0001 || dload !== 32'hCAFE_0001) begin errors++; $display("FAIL load_pass got %h/%h exp cafe0001", iload, dload); end
  endtask

  task automatic test_icache();
    iREN = 1; iaddr = 32'h40; ramload = 32'hDEAD_BEEF; #1;
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL ic_arb got ren=%b iwait=%b exp 0 1", ramREN, iwait); end
    at_neg(); #1;
    checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin errors++; $display("FAIL ic_acc got ren=%b wen=%b addr=%h exp 1 0 40", ramREN, ramWEN, ramaddr); end
    checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL ic_wait got %b exp 1", iwait); end
    at_neg(); ramready = 1; #1;
    checks++; if (iwait !== 1'b0 || iload !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ic_done got iwait=%b iload=%h exp 0 deadbeef", iwait, iload); end
    checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL ic_dwait got %b exp 1", dwait); end
    at_neg(); iREN = 0; ramready = 0; #1;
    checks++; if (dut.state !== S_IDLE || ramREN !== 1'b0) begin errors++; $display("FAIL ic_back_idle got state=%0d ren=%b exp 0 0", dut.state, ramREN); end
    // abort: iREN drops while the access is pending
    at_neg(); iREN = 1; iaddr = 32'h48;
    at_neg(); #1;
    checks++; if (dut.state !== S_IACC) begin errors++; $display("FAIL ic_abort_pre got %0d exp %0d", dut.state, S_IACC); end
    iREN = 0;
    at_neg(); #1;
    checks++; if (dut.state !== S_IDLE || ramREN !== 1'b0) begin errors++; $display("FAIL ic_abort got state=%0d ren=%b exp 0 0", dut.state, ramREN); end
  endtask

  task automatic test_back_to_back();
    at_neg(); iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100; dstore = 32'hA1; #1;
    at_neg(); ramready = 1; #1;
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h100 || ramstore !== 32'hA1) begin errors++; $display("FAIL blk_w0 got wen=%b ren=%b addr=%h st=%h exp 1 0 100 a1", ramWEN, ramREN, ramaddr, ramstore); end
    checks++; if (dwait !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL blk_w0_wait got d=%b i=%b exp 0 1", dwait, iwait); end
    checks++; if (dut.starve_cnt !== 3'd1) begin errors++; $display("FAIL blk_cnt1 got %0d exp 1", dut.starve_cnt); end
    at_neg(); ramready = 0; daddr = 32'h104; dstore = 32'hB2; #1;
    checks++; if (dut.state !== S_DHOLD || ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0) begin errors++; $display("FAIL blk_hold got state=%0d ren=%b wen=%b addr=%h exp 3 0 0 0", dut.state, ramREN, ramWEN, ramaddr); end
    checks++; if (dwait !== 1'b1 || iwait !== 1'b1) begin errors++; $display("FAIL blk_hold_wait got d=%b i=%b exp 1 1", dwait, iwait); end
    at_neg(); ramready = 1; #1;
    checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h104 || ramstore !== 32'hB2) begin errors++; $display("FAIL blk_w1 got wen=%b addr=%h st=%h exp 1 104 b2", ramWEN, ramaddr, ramstore); end
    checks++; if (dut.starve_cnt !== 3'd1) begin errors++; $display("FAIL blk_hold_cnt got %0d exp 1", dut.starve_cnt); end
    at_neg(); dWEN = 0; ramready = 0; #1;
    checks++; if (dut.state !== S_IDLE) begin errors++; $display("FAIL blk_idle got %0d exp 0", dut.state); end
    at_neg(); #1;
    checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h80) begin errors++; $display("FAIL blk_igrant got ren=%b wen=%b addr=%h exp 1 0 80", ramREN, ramWEN, ramaddr); end
    checks++; if (dut.starve_cnt !== 3'd0) begin errors++; $display("FAIL blk_cnt_clr got %0d exp 0", dut.starve_cnt); end
    ramready = 1;
    at_neg(); iREN = 0; ramready = 0;
  endtask

  task automatic test_starvation();
    iREN = 1; iaddr = 32'h300; dREN = 1; daddr = 32'h204; ramload = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (dut.state !== S_IDLE) begin errors++; $display("FAIL stv_idle%0d got %0d exp 0", i, dut.state); end
      at_neg(); ramready = 1; #1;
      checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h204 || dload !== 32'h5555_AAAA) begin errors++; $display("FAIL stv_rd%0d got ren=%b addr=%h dload=%h exp 1 204 5555aaaa", i, ramREN, ramaddr, dload); end
      checks++; if (dut.starve_cnt !== 3'(i + 1)) begin errors++; $display("FAIL stv_cnt%0d got %0d exp %0d", i, dut.starve_cnt, i + 1); end
      at_neg(); ramready = 0;
    end
    at_neg(); #1;
    checks++; if (dut.state !== S_IACC || ramREN !== 1'b1 || ramaddr !== 32'h300) begin errors++; $display("FAIL stv_igrant got state=%0d ren=%b addr=%h exp 1 1 300", dut.state, ramREN, ramaddr); end
    checks++; if (dut.starve_cnt !== 3'd0) begin errors++; $display("FAIL stv_cnt_clr got %0d exp 0", dut.starve_cnt); end
    ramready = 1;
    at_neg(); iREN = 0; dREN = 0; ramready = 0;
  endtask

  task automatic test_write_priority();
    dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'h1234_5678;
    at_neg(); #1;
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1234_5678 || ramaddr !== 32'h200) begin errors++; $display("FAIL wp got wen=%b ren=%b st=%h addr=%h exp 1 0 12345678 200", ramWEN, ramREN, ramstore, ramaddr); end
    at_neg(); dREN = 0; dWEN = 0; #1;
    checks++; if (dut.state !== S_DACC || ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL dabort_pre got state=%0d ren=%b wen=%b exp 2 0 0", dut.state, ramREN, ramWEN); end
    at_neg(); #1;
    checks++; if (dut.state !== S_IDLE) begin errors++; $display("FAIL dabort got %0d exp 0", dut.state); end
  endtask

  task automatic test_reset_mid();
    iREN = 1; iaddr = 32'h44;
    at_neg(); #1;
    checks++; if (dut.state !== S_IACC) begin errors++; $display("FAIL rst_i_pre got %0d exp 1", dut.state); end
    RST = 1;
    at_neg(); RST = 0; #1;
    checks++; if (dut.state !== S_IDLE || ramREN !== 1'b0 || iwait !== 1'b1 || ramaddr !== 32'h0) begin errors++; $display("FAIL rst_iacc got state=%0d ren=%b iwait=%b addr=%h exp 0 0 1 0", dut.state, ramREN, iwait, ramaddr); end
    checks++; if (dut.starve_cnt !== 3'd0) begin errors++; $display("FAIL rst_iacc_cnt got %0d exp 0", dut.starve_cnt); end
    // reset during a dcache access with a nonzero counter
    dREN = 1; daddr = 32'h20C;
    at_neg(); #1;
    checks++; if (dut.state !== S_DACC || dut.starve_cnt !== 3'd1) begin errors++; $display("FAIL rst_d_pre got state=%0d cnt=%0d exp 2 1", dut.state, dut.starve_cnt); end
    RST = 1;
    at_neg(); RST = 0; iREN = 0; dREN = 0; #1;
    checks++; if (dut.state !== S_IDLE || dut.starve_cnt !== 3'd0 || dwait !== 1'b1) begin errors++; $display("FAIL rst_dacc got state=%0d cnt=%0d dwait=%b exp 0 0 1", dut.state, dut.starve_cnt, dwait); end
  endtask

  // Read and write enables must never both be active.
  always @(negedge CLK) begin
    if (RST === 1'b0 && ramREN === 1'b1 && ramWEN === 1'b1) begin
      errors++;
      $display("FAIL ram_excl got ren=1 wen=1 exp not both");
    end
  end

  initial begin
    test_reset();
    test_icache();
    at_neg();
    test_back_to_back();
    at_neg();
    test_starvation();
    at_neg();
    test_write_priority();
    at_neg();
    test_reset_mid();
    at_neg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
